// File: rtl/ap_ctrl_perf_monitor.sv
// ap_ctrl_perf_monitor
//   Watches NUM_CH ap_ctrl_chain handshakes. For each channel it measures:
//     - transaction count
//     - start-to-done latency (last/min/max)
//     - initiation interval
//     - done-stall cycles
//   Up to DEPTH start timestamps per channel may be outstanding, so pipelined
//   sub-functions are measured correctly.
//
// Ports
//   clock        system clock, rising edge
//   reset_n      asynchronous active-low reset
//   ap_start     per-channel handshake input
//   ap_ready     per-channel handshake input
//   ap_done      per-channel handshake input
//   ap_continue  per-channel handshake input
//   finish       freezes statistics; FIFOs and FSMs keep tracking
//   clear        synchronous clear of statistics, FIFOs and flags
//   rd_sel       readout channel select
//   rd_field     readout statistic select:
//                  0 txn, 1 last, 2 min, 3 max, 4 interval,
//                  5 stall, 6 occupancy, 7 {ovf,udf}
//   rd_data      registered readout, one cycle after rd_sel/rd_field
//   err_any      registered OR of all sticky overflow/underflow flags
`timescale 1ns/1ps
module ap_ctrl_perf_monitor #(
    parameter int NUM_CH = 4,
    parameter int DEPTH  = 4,
    parameter int TS_W   = 16,
    parameter int CNT_W  = 32,
    localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [NUM_CH-1:0] ap_start,
    input  logic [NUM_CH-1:0] ap_ready,
    input  logic [NUM_CH-1:0] ap_done,
    input  logic [NUM_CH-1:0] ap_continue,
    input  logic              finish,
    input  logic              clear,
    input  logic [SEL_W-1:0]  rd_sel,
    input  logic [2:0]        rd_field,
    output logic [CNT_W-1:0]  rd_data,
    output logic              err_any
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_HOLD} state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [TS_W-1:0]  ts;
    logic [TS_W-1:0]  fifo_mem [NUM_CH][DEPTH];
    logic [PTR_W-1:0] wr_ptr   [NUM_CH];
    logic [PTR_W-1:0] rd_ptr   [NUM_CH];
    logic [OCC_W-1:0] occ      [NUM_CH];
    logic [OCC_W-1:0] occ_nxt  [NUM_CH];
    state_t           state    [NUM_CH];
    state_t           state_nxt[NUM_CH];

    logic [NUM_CH-1:0] ev_s, ev_d, ev_stall, is_empty, is_full, bypass;
    logic [NUM_CH-1:0] do_push, do_pop, lat_vld, set_ovf, set_udf;
    logic [TS_W-1:0]   lat_ts [NUM_CH];
    logic [CNT_W-1:0]  lat    [NUM_CH];

    logic [CNT_W-1:0] txn_cnt [NUM_CH];
    logic [CNT_W-1:0] last_lat[NUM_CH];
    logic [CNT_W-1:0] min_lat [NUM_CH];
    logic [CNT_W-1:0] max_lat [NUM_CH];
    logic [CNT_W-1:0] last_ivl[NUM_CH];
    logic [CNT_W-1:0] ivl_run [NUM_CH];
    logic [CNT_W-1:0] stall_cnt[NUM_CH];
    logic [NUM_CH-1:0] seen_s, ovf_flag, udf_flag;
    logic [CNT_W-1:0] rd_mux;

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)   ts <= '0;
        else if (clear) ts <= '0;
        else            ts <= ts + 1'b1;
    end

    // Event decode: the FSM output process. Occupancy, not FSM state,
    // decides push/pop, so finish can never desynchronise the two.
    always_comb begin
        // NOTE: every combinational output gets a default first so no
        // path leaves it unassigned and no latch is inferred.
        ev_s = '0; ev_d = '0; ev_stall = '0; is_empty = '0; is_full = '0;
        bypass = '0; do_push = '0; do_pop = '0; lat_vld = '0;
        set_ovf = '0; set_udf = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            ev_s[c]     = ap_start[c] & ap_ready[c];
            ev_d[c]     = ap_done[c] & ap_continue[c];
            ev_stall[c] = ap_done[c] & ~ap_continue[c];
            is_empty[c] = (occ[c] == '0);
            is_full[c]  = (occ[c] == OCC_W'(DEPTH));
            bypass[c]   = ev_s[c] & ev_d[c] & is_empty[c];
            do_pop[c]   = ev_d[c] & ~is_empty[c];
            // A full FIFO still accepts a push when the same cycle pops.
            do_push[c]  = ev_s[c] & ~bypass[c] & (~is_full[c] | ev_d[c]);
            set_ovf[c]  = ev_s[c] & is_full[c] & ~ev_d[c];
            set_udf[c]  = ev_d[c] & is_empty[c] & ~ev_s[c];
            lat_vld[c]  = bypass[c] | do_pop[c];
            // Subtract at TS_W first so the latency wraps modulo 2^TS_W.
            lat_ts[c]   = bypass[c] ? '0 : ts - fifo_mem[c][rd_ptr[c]];
            lat[c]      = CNT_W'(lat_ts[c]);
            occ_nxt[c]  = occ[c] + OCC_W'(do_push[c]) - OCC_W'(do_pop[c]);
        end
    end

    // Next-state process.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            state_nxt[c] = state[c];
            unique case (state[c])
                ST_IDLE:   if (do_push[c]) state_nxt[c] = ST_ACTIVE;
                ST_ACTIVE: if (occ_nxt[c] == '0) state_nxt[c] = ST_IDLE;
                           else if (ev_stall[c]) state_nxt[c] = ST_HOLD;
                ST_HOLD:   if (ev_d[c])
                               state_nxt[c] = (occ_nxt[c] == '0) ? ST_IDLE : ST_ACTIVE;
                default:   state_nxt[c] = ST_IDLE;
            endcase
        end
    end

    // State register plus FIFO pointers and occupancy.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                state[c] <= ST_IDLE; wr_ptr[c] <= '0; rd_ptr[c] <= '0; occ[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (clear) begin
                    state[c] <= ST_IDLE; wr_ptr[c] <= '0; rd_ptr[c] <= '0; occ[c] <= '0;
                end else begin
                    state[c] <= state_nxt[c];
                    occ[c]   <= occ_nxt[c];
                    if (do_push[c]) wr_ptr[c] <= wr_ptr[c] + 1'b1;
                    if (do_pop[c])  rd_ptr[c] <= rd_ptr[c] + 1'b1;
                end
            end
        end
    end

    // NOTE: timestamp storage has no reset; occupancy guards every read,
    // so stale contents are never observed.
    always_ff @(posedge clock) begin
        for (int c = 0; c < NUM_CH; c++)
            if (do_push[c] && !clear) fifo_mem[c][wr_ptr[c]] <= ts;
    end

    // Statistics. The interval run counter and seen_s keep tracking under
    // finish; only the recorded values freeze.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            seen_s <= '0; ovf_flag <= '0; udf_flag <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                txn_cnt[c] <= '0; last_lat[c] <= '0; min_lat[c] <= '1; max_lat[c] <= '0;
                last_ivl[c] <= '0; ivl_run[c] <= '0; stall_cnt[c] <= '0;
            end
        end else if (clear) begin
            seen_s <= '0; ovf_flag <= '0; udf_flag <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                txn_cnt[c] <= '0; last_lat[c] <= '0; min_lat[c] <= '1; max_lat[c] <= '0;
                last_ivl[c] <= '0; ivl_run[c] <= '0; stall_cnt[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (ev_s[c]) begin
                    seen_s[c]  <= 1'b1;
                    ivl_run[c] <= CNT_W'(1);
                end else begin
                    ivl_run[c] <= sat_inc(ivl_run[c]);
                end
                if (!finish) begin
                    if (ev_s[c] && seen_s[c]) last_ivl[c] <= ivl_run[c];
                    if (lat_vld[c]) begin
                        txn_cnt[c]  <= sat_inc(txn_cnt[c]);
                        last_lat[c] <= lat[c];
                        if (lat[c] < min_lat[c]) min_lat[c] <= lat[c];
                        if (lat[c] > max_lat[c]) max_lat[c] <= lat[c];
                    end
                    if (ev_stall[c]) stall_cnt[c] <= sat_inc(stall_cnt[c]);
                    if (set_ovf[c])  ovf_flag[c]  <= 1'b1;
                    if (set_udf[c])  udf_flag[c]  <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        if (int'(rd_sel) < NUM_CH) begin
            unique case (rd_field)
                3'd0: rd_mux = txn_cnt[rd_sel];
                3'd1: rd_mux = last_lat[rd_sel];
                3'd2: rd_mux = min_lat[rd_sel];
                3'd3: rd_mux = max_lat[rd_sel];
                3'd4: rd_mux = last_ivl[rd_sel];
                3'd5: rd_mux = stall_cnt[rd_sel];
                3'd6: rd_mux = CNT_W'(occ[rd_sel]);
                3'd7: rd_mux = CNT_W'({ovf_flag[rd_sel], udf_flag[rd_sel]});
                default: rd_mux = '0;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_data <= '0;
            err_any <= 1'b0;
        end else if (clear) begin
            rd_data <= '0;
            err_any <= 1'b0;
        end else begin
            rd_data <= rd_mux;
            err_any <= |{ovf_flag, udf_flag};
        end
    end

endmodule

// File: tb/tb_ap_ctrl_perf_monitor.sv
// tb_ap_ctrl_perf_monitor
//   Directed scenarios for ap_ctrl_perf_monitor (default parameters):
//     reset, sequential, pipelined, overflow, stall, back-to-back/underflow,
//     finish/clear.
//   Expected values are hand-computed from edge counts between accepted events.
`timescale 1ns/1ps
module tb_ap_ctrl_perf_monitor;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [3:0]  ap_start, ap_ready, ap_done, ap_continue;
    logic        finish, clear;
    logic [1:0]  rd_sel;
    logic [2:0]  rd_field;
    logic [31:0] rd_data;
    logic        err_any;

    int passed = 0;
    int total  = 0;

    ap_ctrl_perf_monitor #(.NUM_CH(4), .DEPTH(4), .TS_W(16), .CNT_W(32)) dut (
        .clock(clock), .reset_n(reset_n),
        .ap_start(ap_start), .ap_ready(ap_ready),
        .ap_done(ap_done), .ap_continue(ap_continue),
        .finish(finish), .clear(clear),
        .rd_sel(rd_sel), .rd_field(rd_field),
        .rd_data(rd_data), .err_any(err_any)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic read_field(input int ch, input int f, output logic [31:0] v);
        rd_sel   = ch[1:0];
        rd_field = f[2:0];
        tick();
        v = rd_data;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        int          f_l[8] = '{0, 1, 2, 3, 4, 5, 6, 7};
        logic [31:0] e_l[8] = '{0, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0};
        reset_n = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        tick();
        ap_start[0] = 1'b1; tick(); ap_start[0] = 1'b0;
        tick();
        reset_n = 1'b0;
        #1;
        total++;
        if (rd_data !== 32'd0 || err_any !== 1'b0)
            $display("FAIL reset_async: got %0h/%0b expected 0/0", rd_data, err_any);
        else passed++;
        tick(); tick();
        reset_n = 1'b1;
        foreach (f_l[i]) begin
            read_field(0, f_l[i], v);
            total++;
            if (v !== e_l[i]) $display("FAIL reset_field%0d: got %0h expected %0h", f_l[i], v, e_l[i]);
            else passed++;
        end
        total++;
        if (err_any !== 1'b0) $display("FAIL reset_err_any: got %0b expected 0", err_any);
        else passed++;
    endtask

    task automatic test_sequential();
        logic [31:0] v;
        int          f_l[6] = '{0, 1, 2, 3, 6, 7};
        logic [31:0] e_l[6] = '{1, 7, 7, 7, 0, 0};
        ap_start[0] = 1'b1; tick(); ap_start[0] = 1'b0;   // S at edge e
        read_field(0, 6, v);                              // edge e+1
        total++;
        if (v !== 32'd1) $display("FAIL seq_occ_mid: got %0d expected 1", v);
        else passed++;
        repeat (5) tick();                                // edges e+2..e+6
        ap_done[0] = 1'b1; tick(); ap_done[0] = 1'b0;     // D at edge e+7
        foreach (f_l[i]) begin
            read_field(0, f_l[i], v);
            total++;
            if (v !== e_l[i]) $display("FAIL seq_field%0d: got %0d expected %0d", f_l[i], v, e_l[i]);
            else passed++;
        end
    endtask

    task automatic test_pipelined();
        logic [31:0] v;
        logic [31:0] occ_max = 0;
        int          f_l[7] = '{0, 1, 2, 3, 4, 6, 7};
        logic [31:0] e_l[7] = '{3, 5, 5, 5, 2, 0, 0};
        rd_sel = 2'd1; rd_field = 3'd6;
        for (int t = 0; t < 10; t++) begin
            ap_start[1] = (t == 0 || t == 2 || t == 4);
            ap_done[1]  = (t == 5 || t == 7 || t == 9);
            tick();
            if (rd_data > occ_max) occ_max = rd_data;
        end
        ap_start[1] = 1'b0; ap_done[1] = 1'b0;
        tick();
        total++;
        if (occ_max !== 32'd3) $display("FAIL pipe_occ_max: got %0d expected 3", occ_max);
        else passed++;
        foreach (f_l[i]) begin
            read_field(1, f_l[i], v);
            total++;
            if (v !== e_l[i]) $display("FAIL pipe_field%0d: got %0d expected %0d", f_l[i], v, e_l[i]);
            else passed++;
        end
    endtask

    task automatic test_overflow();
        logic [31:0] v;
        int          f_l[5] = '{0, 1, 4, 6, 7};
        logic [31:0] e_l[5] = '{1, 7, 1, 3, 2};
        ap_start[2] = 1'b1; repeat (5) tick(); ap_start[2] = 1'b0;  // edges e..e+4
        read_field(2, 7, v);                                        // edge e+5
        total++;
        if (v !== 32'd2) $display("FAIL ovf_flags: got %0d expected 2", v);
        else passed++;
        total++;
        if (err_any !== 1'b1) $display("FAIL ovf_err_any: got %0b expected 1", err_any);
        else passed++;
        read_field(2, 6, v);                                        // edge e+6
        total++;
        if (v !== 32'd4) $display("FAIL ovf_occ_full: got %0d expected 4", v);
        else passed++;
        ap_done[2] = 1'b1; tick(); ap_done[2] = 1'b0;               // D at edge e+7
        foreach (f_l[i]) begin
            read_field(2, f_l[i], v);
            total++;
            if (v !== e_l[i]) $display("FAIL ovf_field%0d: got %0d expected %0d", f_l[i], v, e_l[i]);
            else passed++;
        end
    endtask

    task automatic test_stall();
        logic [31:0] v;
        int          f_l[5] = '{0, 1, 5, 6, 7};
        logic [31:0] e_l[5] = '{1, 7, 6, 0, 0};
        ap_start[3] = 1'b1; tick(); ap_start[3] = 1'b0;             // S at edge e
        ap_done[3] = 1'b1; ap_continue[3] = 1'b0;
        repeat (6) tick();                                          // stalls e+1..e+6
        ap_continue[3] = 1'b1; tick();                              // D at edge e+7
        ap_done[3] = 1'b0;
        foreach (f_l[i]) begin
            read_field(3, f_l[i], v);
            total++;
            if (v !== e_l[i]) $display("FAIL stall_field%0d: got %0d expected %0d", f_l[i], v, e_l[i]);
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] v;
        int          f_l[6] = '{0, 1, 2, 3, 6, 7};
        logic [31:0] e_l[6] = '{2, 0, 0, 7, 0, 0};
        int          g_l[3] = '{7, 0, 1};
        logic [31:0] h_l[3] = '{1, 2, 0};
        ap_start[0] = 1'b1; ap_done[0] = 1'b1; tick();              // bypass
        ap_start[0] = 1'b0; ap_done[0] = 1'b0;
        foreach (f_l[i]) begin
            read_field(0, f_l[i], v);
            total++;
            if (v !== e_l[i]) $display("FAIL b2b_field%0d: got %0d expected %0d", f_l[i], v, e_l[i]);
            else passed++;
        end
        ap_done[0] = 1'b1; tick(); ap_done[0] = 1'b0;               // underflow
        foreach (g_l[i]) begin
            read_field(0, g_l[i], v);
            total++;
            if (v !== h_l[i]) $display("FAIL udf_field%0d: got %0d expected %0d", g_l[i], v, h_l[i]);
            else passed++;
        end
    endtask

    task automatic test_finish_clear();
        logic [31:0] v;
        int          f_l[8] = '{0, 1, 2, 3, 4, 5, 6, 7};
        logic [31:0] e_l[8] = '{0, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0};
        ap_start[0] = 1'b1; tick(); ap_start[0] = 1'b0;
        tick(); tick();
        finish = 1'b1;
        ap_done[0] = 1'b1; tick(); ap_done[0] = 1'b0;
        read_field(0, 0, v);
        total++;
        if (v !== 32'd2) $display("FAIL fin_txn_hold: got %0d expected 2", v);
        else passed++;
        read_field(0, 1, v);
        total++;
        if (v !== 32'd0) $display("FAIL fin_last_hold: got %0d expected 0", v);
        else passed++;
        read_field(0, 6, v);
        total++;
        if (v !== 32'd0) $display("FAIL fin_occ_tracks: got %0d expected 0", v);
        else passed++;
        finish = 1'b0;
        read_field(0, 3, v);
        total++;
        if (v !== 32'd7) $display("FAIL fin_max_pre_clear: got %0d expected 7", v);
        else passed++;
        clear = 1'b1; tick(); clear = 1'b0;
        total++;
        if (rd_data !== 32'd0 || err_any !== 1'b0)
            $display("FAIL clr_outputs: got %0h/%0b expected 0/0", rd_data, err_any);
        else passed++;
        foreach (f_l[i]) begin
            read_field(0, f_l[i], v);
            total++;
            if (v !== e_l[i]) $display("FAIL clr_field%0d: got %0h expected %0h", f_l[i], v, e_l[i]);
            else passed++;
        end
        read_field(2, 6, v);
        total++;
        if (v !== 32'd0) $display("FAIL clr_ch2_occ: got %0d expected 0", v);
        else passed++;
        read_field(2, 7, v);
        total++;
        if (v !== 32'd0) $display("FAIL clr_ch2_flags: got %0d expected 0", v);
        else passed++;
        total++;
        if (err_any !== 1'b0) $display("FAIL clr_err_any: got %0b expected 0", err_any);
        else passed++;
    endtask

    initial begin
        reset_n = 1'b0;
        ap_start = '0; ap_ready = '1; ap_done = '0; ap_continue = '1;
        finish = 1'b0; clear = 1'b0; rd_sel = '0; rd_field = '0;
        test_reset();
        test_sequential();
        test_pipelined();
        test_overflow();
        test_stall();
        test_back_to_back();
        test_finish_clear();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
